// File: rtl/rle_pkg.sv
// Shared types and constants for the run-length stream encoder.
package rle_pkg;

  typedef enum logic [2:0] {
    IDLE,
    ACCUM,
    EMIT_CNT,
    EMIT_LIT,
    FLUSH
  } rle_state_e;

  localparam logic FLAG_CNT = 1'b1;
  localparam logic FLAG_LIT = 1'b0;
  localparam int   STAT_W   = 32;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/rle_out_slice.sv
// Output register slice: one-deep, full throughput; word is held stable while out_vld && !out_rdy.
module rle_out_slice #(
  parameter int W = 10
) (
  input  logic         clock,
  input  logic         reset_n,
  input  logic         in_vld,
  output logic         in_rdy,
  input  logic [W-1:0] in_dat,
  output logic         out_vld,
  input  logic         out_rdy,
  output logic [W-1:0] out_dat
);

  logic         vld_q, vld_d;
  logic [W-1:0] dat_q, dat_d;

  assign in_rdy  = !vld_q || out_rdy;
  assign out_vld = vld_q;
  assign out_dat = dat_q;

  always_comb begin
    vld_d = vld_q;
    dat_d = dat_q;
    if (in_vld && in_rdy) begin
      vld_d = 1'b1;
      dat_d = in_dat;
    end else if (out_rdy) begin
      vld_d = 1'b0;
    end
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      vld_q <= 1'b0;
      dat_q <= '0;
    end else begin
      vld_q <= vld_d;
      dat_q <= dat_d;
    end
  end

endmodule

// File: rtl/rle_stream_encoder.sv
// Run-length encoder: symbols in, count/literal tokens out; first token one cycle after the run ends.
// in_ready is low while a run drains; tokens hold under out_ready low. RLE_STREAM_STATS_EN adds counters.
module rle_stream_encoder
  import rle_pkg::*;
#(
  parameter int  DATA_W  = 7,
  parameter int  CNT_W   = 8,
  parameter int  MIN_RUN = 2,
  localparam int OUT_W   = max_int(DATA_W, CNT_W) + 1
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_last,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [OUT_W-1:0]  out_data,
  output logic              out_last
`ifdef RLE_STREAM_STATS_EN
  ,
  output logic [STAT_W-1:0] stat_sym,
  output logic [STAT_W-1:0] stat_tok
`endif
);

  localparam int               PAY_W   = OUT_W - 1;
  localparam logic [CNT_W-1:0] RUN_MAX = '1;
  localparam logic [CNT_W-1:0] MIN_CNT = MIN_RUN[CNT_W-1:0];

  rle_state_e        state_q, state_d;
  logic [DATA_W-1:0] cur_sym_q, cur_sym_d;
  logic [CNT_W-1:0]  run_cnt_q, run_cnt_d;
  logic [CNT_W-1:0]  lit_cnt_q, lit_cnt_d;
  logic              pend_vld_q, pend_vld_d;
  logic [DATA_W-1:0] pend_sym_q, pend_sym_d;
  logic              pend_last_q, pend_last_d;
  logic              last_q, last_d;

  logic              emit_go;
  logic [DATA_W-1:0] emit_sym;
  logic [CNT_W-1:0]  emit_cnt;
  logic              emit_fin;

  logic              tok_vld, tok_rdy;
  logic [OUT_W:0]    tok_dat, slc_dat;
  logic              in_fire, out_fire;

  function automatic logic [OUT_W:0] lit_tok(input logic [DATA_W-1:0] sym, input logic last);
    logic [PAY_W-1:0] pay;
    pay              = '0;
    pay[DATA_W-1:0]  = sym;
    return {last, FLAG_LIT, pay};
  endfunction

  function automatic logic [OUT_W:0] cnt_tok(input logic [CNT_W-1:0] cnt);
    logic [PAY_W-1:0] pay;
    pay             = '0;
    pay[CNT_W-1:0]  = cnt;
    return {1'b0, FLAG_CNT, pay};
  endfunction

  // The slice is always empty in IDLE/ACCUM, so tok_rdy only matters structurally there.
  assign in_ready = reset_n && tok_rdy && (state_q == IDLE || state_q == ACCUM);
  assign in_fire  = in_valid && in_ready;
  assign out_fire = out_valid && out_ready;
  assign out_data = slc_dat[OUT_W-1:0];
  assign out_last = slc_dat[OUT_W];

  always_comb begin
    state_d     = state_q;
    cur_sym_d   = cur_sym_q;
    run_cnt_d   = run_cnt_q;
    lit_cnt_d   = lit_cnt_q;
    pend_vld_d  = pend_vld_q;
    pend_sym_d  = pend_sym_q;
    pend_last_d = pend_last_q;
    last_d      = last_q;
    emit_go     = 1'b0;
    emit_sym    = cur_sym_q;
    emit_cnt    = run_cnt_q;
    emit_fin    = 1'b0;
    tok_vld     = 1'b0;
    tok_dat     = '0;

    case (state_q)
      IDLE: begin
        if (in_fire) begin
          cur_sym_d = in_data;
          run_cnt_d = CNT_W'(1);
          if (in_last) begin
            emit_go  = 1'b1;
            emit_sym = in_data;
            emit_cnt = CNT_W'(1);
            emit_fin = 1'b1;
          end else begin
            state_d = ACCUM;
          end
        end
      end
      ACCUM: begin
        if (in_fire) begin
          if (in_data == cur_sym_q && run_cnt_q != RUN_MAX) begin
            run_cnt_d = run_cnt_q + CNT_W'(1);
            if (in_last) begin
              emit_go  = 1'b1;
              emit_cnt = run_cnt_q + CNT_W'(1);
              emit_fin = 1'b1;
            end
          end else begin
            emit_go     = 1'b1;
            pend_vld_d  = 1'b1;
            pend_sym_d  = in_data;
            pend_last_d = in_last;
          end
        end
      end
      EMIT_CNT: begin
        if (out_fire) begin
          tok_vld   = 1'b1;
          tok_dat   = lit_tok(cur_sym_q, last_q);
          lit_cnt_d = CNT_W'(1);
          state_d   = last_q ? FLUSH : EMIT_LIT;
        end
      end
      EMIT_LIT, FLUSH: begin
        if (out_fire) begin
          if (lit_cnt_q > CNT_W'(1)) begin
            tok_vld   = 1'b1;
            tok_dat   = lit_tok(cur_sym_q, state_q == FLUSH && lit_cnt_q == CNT_W'(2));
            lit_cnt_d = lit_cnt_q - CNT_W'(1);
          end else if (state_q == FLUSH) begin
            state_d   = IDLE;
            last_d    = 1'b0;
            run_cnt_d = '0;
          end else if (pend_vld_q) begin
            pend_vld_d = 1'b0;
            cur_sym_d  = pend_sym_q;
            run_cnt_d  = CNT_W'(1);
            if (pend_last_q) begin
              emit_go  = 1'b1;
              emit_sym = pend_sym_q;
              emit_cnt = CNT_W'(1);
              emit_fin = 1'b1;
            end else begin
              state_d = ACCUM;
            end
          end else begin
            state_d   = IDLE;
            run_cnt_d = '0;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    // Start draining a finished run: its first token enters the slice this cycle.
    if (emit_go) begin
      tok_vld   = 1'b1;
      last_d    = emit_fin;
      lit_cnt_d = emit_cnt;
      if (emit_cnt >= MIN_CNT) begin
        tok_dat = cnt_tok(emit_cnt);
        state_d = EMIT_CNT;
      end else begin
        tok_dat = lit_tok(emit_sym, emit_fin && emit_cnt == CNT_W'(1));
        state_d = emit_fin ? FLUSH : EMIT_LIT;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      cur_sym_q   <= '0;
      run_cnt_q   <= '0;
      lit_cnt_q   <= '0;
      pend_vld_q  <= 1'b0;
      pend_sym_q  <= '0;
      pend_last_q <= 1'b0;
      last_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cur_sym_q   <= cur_sym_d;
      run_cnt_q   <= run_cnt_d;
      lit_cnt_q   <= lit_cnt_d;
      pend_vld_q  <= pend_vld_d;
      pend_sym_q  <= pend_sym_d;
      pend_last_q <= pend_last_d;
      last_q      <= last_d;
    end
  end

  rle_out_slice #(
    .W(OUT_W + 1)
  ) u_out_slice (
    .clock  (clock),
    .reset_n(reset_n),
    .in_vld (tok_vld),
    .in_rdy (tok_rdy),
    .in_dat (tok_dat),
    .out_vld(out_valid),
    .out_rdy(out_ready),
    .out_dat(slc_dat)
  );

`ifdef RLE_STREAM_STATS_EN
  logic [STAT_W-1:0] stat_sym_q, stat_sym_d;
  logic [STAT_W-1:0] stat_tok_q, stat_tok_d;

  always_comb begin
    stat_sym_d = stat_sym_q;
    stat_tok_d = stat_tok_q;
    if (in_fire && stat_sym_q != '1) stat_sym_d = stat_sym_q + STAT_W'(1);
    if (out_fire && stat_tok_q != '1) stat_tok_d = stat_tok_q + STAT_W'(1);
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      stat_sym_q <= '0;
      stat_tok_q <= '0;
    end else begin
      stat_sym_q <= stat_sym_d;
      stat_tok_q <= stat_tok_d;
    end
  end

  assign stat_sym = stat_sym_q;
  assign stat_tok = stat_tok_q;
`else
  // Counters are not built in this configuration.
`endif

endmodule

// File: tb/tb_rle_stream_encoder.sv
// Bench for rle_stream_encoder: a packet-level run-splitting model feeds a scoreboard, plus hand-pinned tokens.
module tb_rle_stream_encoder;

  logic             clock;
  logic [1:0]       reset_n, in_valid, in_ready, in_last;
  logic [1:0]       out_valid, out_ready, out_last;
  logic [1:0][6:0]  in_data;
  logic [1:0][8:0]  out_data;
`ifdef RLE_STREAM_STATS_EN
  logic [1:0][31:0] stat_sym, stat_tok;
`endif

  int total = 0;
  int bad   = 0;
  logic [9:0] exp_q0[$];
  logic [9:0] exp_q1[$];
  logic [6:0] pkt[$];

  rle_stream_encoder #(.DATA_W(7), .CNT_W(8), .MIN_RUN(2)) dut0 (
    .clock(clock), .reset_n(reset_n[0]),
    .in_valid(in_valid[0]), .in_ready(in_ready[0]), .in_data(in_data[0]), .in_last(in_last[0]),
    .out_valid(out_valid[0]), .out_ready(out_ready[0]), .out_data(out_data[0]), .out_last(out_last[0])
`ifdef RLE_STREAM_STATS_EN
    , .stat_sym(stat_sym[0]), .stat_tok(stat_tok[0])
`endif
  );

  rle_stream_encoder #(.DATA_W(7), .CNT_W(8), .MIN_RUN(3)) dut1 (
    .clock(clock), .reset_n(reset_n[1]),
    .in_valid(in_valid[1]), .in_ready(in_ready[1]), .in_data(in_data[1]), .in_last(in_last[1]),
    .out_valid(out_valid[1]), .out_ready(out_ready[1]), .out_data(out_data[1]), .out_last(out_last[1])
`ifdef RLE_STREAM_STATS_EN
    , .stat_sym(stat_sym[1]), .stat_tok(stat_tok[1])
`endif
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, want);
    end
  endtask

  task automatic timeout_fail(input string name);
    total++;
    bad++;
    $display("FAIL %s: got timeout want event", name);
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic push(input int k, input logic [9:0] t);
    if (k == 0) exp_q0.push_back(t);
    else        exp_q1.push_back(t);
  endtask

  function automatic int qsize(input int k);
    return (k == 0) ? exp_q0.size() : exp_q1.size();
  endfunction

  // Token = {last, flag, 8-bit payload}; a packet splits into runs of at most 255.
  task automatic expect_pkt(input int k, input logic [6:0] syms[$]);
    int mr = (k == 0) ? 2 : 3;
    int n  = syms.size();
    int i  = 0;
    while (i < n) begin
      logic [6:0] s = syms[i];
      int len = 0;
      logic fin;
      while (i < n && syms[i] == s && len < 255) begin
        len++;
        i++;
      end
      fin = (i == n);
      if (len >= mr) begin
        push(k, {2'b01, 8'(len)});
        push(k, {fin, 2'b00, s});
      end else begin
        for (int j = 0; j < len; j++) push(k, {fin && (j == len - 1), 2'b00, s});
      end
    end
  endtask

  task automatic send(input int k, input logic [6:0] s, input logic l);
    int n = 0;
    in_valid[k] = 1'b1;
    in_data[k]  = s;
    in_last[k]  = l;
    do begin
      @(negedge clock);
      n++;
    end while (!in_ready[k] && n < 1000);
    if (!in_ready[k]) timeout_fail("send");
    step();
    in_valid[k] = 1'b0;
    in_last[k]  = 1'b0;
  endtask

  task automatic drive_pkt(input int k, input logic [6:0] syms[$]);
    foreach (syms[i]) send(k, syms[i], i == syms.size() - 1);
  endtask

  task automatic drain(input int k);
    int n = 0;
    do begin
      @(negedge clock);
      n++;
    end while (!(qsize(k) == 0 && !out_valid[k]) && n < 5000);
    if (n >= 5000) timeout_fail("drain");
    step();
  endtask

  always @(negedge clock) begin
    logic [9:0] e;
    for (int k = 0; k < 2; k++) begin
      if (reset_n[k] === 1'b1) begin
        if (out_valid[k]) chk($sformatf("in_ready_low_emit%0d", k), in_ready[k], 0);
        if (out_valid[k] && out_ready[k]) begin
          if (qsize(k) == 0) begin
            total++;
            bad++;
            $display("FAIL extra_token%0d: got %0h want none", k, {out_last[k], out_data[k]});
          end else begin
            if (k == 0) e = exp_q0.pop_front();
            else        e = exp_q1.pop_front();
            chk($sformatf("token%0d", k), {out_last[k], out_data[k]}, e);
          end
        end
      end
    end
  end

  initial begin
    #600000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset_n   = 2'b00;
    in_valid  = 2'b00;
    in_last   = 2'b00;
    in_data   = '0;
    out_ready = 2'b11;
    repeat (3) @(posedge clock);
    @(negedge clock);
    chk("rst_out_valid", out_valid[0], 0);
    chk("rst_out_data", out_data[0], 0);
    chk("rst_out_last", out_last[0], 0);
    chk("rst_in_ready", in_ready[0], 0);
    chk("rst_out_valid1", out_valid[1], 0);
    step();
    reset_n = 2'b11;
    @(negedge clock);
    chk("idle_in_ready", in_ready[0], 1);
    step();

    // Mixed literal and counted run, last on final symbol.
    pkt = '{7'h37, 7'h4B, 7'h4B, 7'h4B};
    expect_pkt(0, pkt);
    chk("model_t1_0", exp_q0[0], 10'h037);
    chk("model_t1_1", exp_q0[1], 10'h103);
    chk("model_t1_2", exp_q0[2], 10'h24B);
    drive_pkt(0, pkt);
    drain(0);
`ifdef RLE_STREAM_STATS_EN
    @(negedge clock);
    chk("stat_sym", stat_sym[0], 4);
    chk("stat_tok", stat_tok[0], 3);
    step();
`endif

    // Saturating run split at 255.
    pkt.delete();
    repeat (300) pkt.push_back(7'h08);
    pkt.push_back(7'h6F);
    expect_pkt(0, pkt);
    chk("model_t2_0", exp_q0[0], 10'h1FF);
    chk("model_t2_1", exp_q0[1], 10'h008);
    chk("model_t2_2", exp_q0[2], 10'h12D);
    chk("model_t2_3", exp_q0[3], 10'h008);
    chk("model_t2_4", exp_q0[4], 10'h26F);
    drive_pkt(0, pkt);
    drain(0);

    // MIN_RUN=3 instance: a run of two stays literal.
    pkt = '{7'h0E, 7'h0E, 7'h17};
    expect_pkt(1, pkt);
    chk("model_t3_0", exp_q1[0], 10'h00E);
    chk("model_t3_1", exp_q1[1], 10'h00E);
    chk("model_t3_2", exp_q1[2], 10'h217);
    drive_pkt(1, pkt);
    drain(1);

    // Backpressure while a count token is presented.
    out_ready[0] = 1'b0;
    pkt = '{7'h33, 7'h33, 7'h33, 7'h33, 7'h33};
    expect_pkt(0, pkt);
    drive_pkt(0, pkt);
    repeat (5) begin
      @(negedge clock);
      chk("bp_valid", out_valid[0], 1);
      chk("bp_data", out_data[0], 9'h105);
      chk("bp_in_ready", in_ready[0], 0);
    end
    step();
    out_ready[0] = 1'b1;
    drain(0);

    // Single symbol with last from IDLE: one token, one cycle later.
    pkt = '{7'h58};
    expect_pkt(0, pkt);
    drive_pkt(0, pkt);
    @(negedge clock);
    chk("single_valid", out_valid[0], 1);
    chk("single_tok", {out_last[0], out_data[0]}, 10'h258);
    drain(0);
    repeat (4) @(negedge clock);
    step();

    // Reset while a literal is presented; pending symbol and partial run are lost.
    out_ready[0] = 1'b0;
    send(0, 7'h11, 1'b0);
    send(0, 7'h11, 1'b0);
    send(0, 7'h22, 1'b0);
    push(0, 10'h102);
    out_ready[0] = 1'b1;
    step();
    out_ready[0] = 1'b0;
    @(negedge clock);
    chk("rst_mid_lit", {out_valid[0], out_data[0]}, 10'h211);
    step();
    reset_n[0] = 1'b0;
    step();
    reset_n[0] = 1'b1;
    @(negedge clock);
    chk("rst_mid_valid", out_valid[0], 0);
    chk("rst_mid_idle", in_ready[0], 1);
    chk("rst_mid_q", qsize(0), 0);
    step();
    out_ready[0] = 1'b1;
    pkt.delete();
    repeat (23) pkt.push_back(7'h2C);
    expect_pkt(0, pkt);
    chk("model_t6_0", exp_q0[0], 10'h117);
    chk("model_t6_1", exp_q0[1], 10'h22C);
    drive_pkt(0, pkt);
    drain(0);

    chk("end_q0_empty", qsize(0), 0);
    chk("end_q1_empty", qsize(1), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
